// File: rtl/mdu_pkg.sv
// Shared opcode encodings, conditioned-entry types and the operand extension helper
// for the MDU operand conditioner.
package mdu_pkg;

  localparam int MDU_PAR = 32;
  localparam int MDU_OPW = 3;

  localparam logic [MDU_OPW-1:0] OP_MUL    = 3'b000;
  localparam logic [MDU_OPW-1:0] OP_MULH   = 3'b001;
  localparam logic [MDU_OPW-1:0] OP_MULHSU = 3'b010;
  localparam logic [MDU_OPW-1:0] OP_MULHU  = 3'b011;
  localparam logic [MDU_OPW-1:0] OP_DIV    = 3'b100;
  localparam logic [MDU_OPW-1:0] OP_DIVU   = 3'b101;
  localparam logic [MDU_OPW-1:0] OP_REM    = 3'b110;
  localparam logic [MDU_OPW-1:0] OP_REMU   = 3'b111;

  typedef struct packed {
    logic [MDU_PAR:0]     op0;
    logic [MDU_PAR:0]     op1;
    logic [MDU_OPW-1:0]   opCode;
    logic                 neg_q;
    logic                 neg_r;
  } cond_core_t;

  // Special-case fields sit below the core so they can be left out of storage.
  typedef struct packed {
    cond_core_t           core;
    logic                 special;
    logic [MDU_PAR-1:0]   special_result;
  } cond_entry_t;

  function automatic logic [MDU_PAR:0] abs_ext(input logic [MDU_PAR-1:0] x,
                                               input logic is_signed,
                                               input logic mag);
    logic               neg;
    logic [MDU_PAR-1:0] mag_x;
    neg   = is_signed & x[MDU_PAR-1];
    mag_x = ~x + MDU_PAR'(1);
    return (mag && neg) ? {1'b0, mag_x} : {neg, x};
  endfunction

endpackage

// File: rtl/mdu_operand_conditioner_if.sv
// Issue-side and datapath-side handshake bundle of the MDU operand conditioner.
interface mdu_operand_conditioner_if #(
  parameter int PAR          = 32,
  parameter int OPCODE_WIDTH = 3
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PAR-1:0]          rs1;
  logic [PAR-1:0]          rs2;
  logic [OPCODE_WIDTH-1:0] opCode;
  logic                    out_valid;
  logic                    out_ready;
  logic [PAR:0]            op0;
  logic [PAR:0]            op1;
  logic [OPCODE_WIDTH-1:0] opCode_out;
  logic                    neg_q;
  logic                    neg_r;
  logic                    special;
  logic [PAR-1:0]          special_result;

  modport slave (
    input  in_valid, rs1, rs2, opCode, out_ready,
    output in_ready, out_valid, op0, op1, opCode_out, neg_q, neg_r, special, special_result
  );

  modport master (
    output in_valid, rs1, rs2, opCode, out_ready,
    input  in_ready, out_valid, op0, op1, opCode_out, neg_q, neg_r, special, special_result
  );
endinterface

// File: rtl/mdu_cond_fifo.sv
// DEPTH-entry synchronous valid/ready FIFO with flush; head entry drives the read data.
module mdu_cond_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_valid_i,
  output logic         wr_ready_o,
  input  logic [W-1:0] wdata_i,
  output logic         rd_valid_o,
  input  logic         rd_ready_i,
  output logic [W-1:0] rdata_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, empty, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (DEPTH == 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (cnt_q == CNT_W'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign wr_ready_o = !full;
  assign rd_valid_o = !empty;
  assign rdata_o    = mem_q[rptr_q];
  // A flush in the same cycle as a write drops the incoming beat.
  assign push       = wr_valid_i && !full && !flush;
  assign pop        = !empty && rd_ready_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push) mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mdu_operand_conditioner.sv
// Conditions rs1/rs2 for the iterative MDU and queues them in a small FIFO.
// Optional divide special-case bypass is enabled by defining MDU_SPECIAL_CASE_EN.
module mdu_operand_conditioner
  import mdu_pkg::*;
#(
  parameter int PAR          = MDU_PAR,
  parameter int OPCODE_WIDTH = MDU_OPW,
  parameter int DEPTH        = 2,
  parameter int ABS_DIV      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  mdu_operand_conditioner_if.slave io
);
  localparam bit MAG_EN = (ABS_DIV != 0);

  logic [PAR-1:0]          rs1, rs2;
  logic [OPCODE_WIDTH-1:0] opc;
  logic                    is_div, div_signed, use_mag, rs2_zero;
  cond_core_t              core_d, core_q;

  assign rs1        = io.rs1;
  assign rs2        = io.rs2;
  assign opc        = io.opCode;
  assign is_div     = opc[2];
  assign div_signed = !opc[0];
  assign use_mag    = MAG_EN && div_signed;
  assign rs2_zero   = (rs2 == '0);

  always_comb begin
    core_d        = '0;
    core_d.opCode = opc;
    if (!is_div) begin
      core_d.op0 = abs_ext(rs2, !opc[1], 1'b0);
      core_d.op1 = abs_ext(rs1, opc != OP_MULHU, 1'b0);
    end else begin
      core_d.op0 = abs_ext(rs2, div_signed, use_mag);
      core_d.op1 = abs_ext(rs1, div_signed, use_mag);
      if (use_mag) begin
        // A zero divisor keeps the quotient sign positive so all-ones stays all-ones.
        core_d.neg_q = (rs1[PAR-1] ^ rs2[PAR-1]) & !rs2_zero;
        core_d.neg_r = rs1[PAR-1];
      end
    end
  end

`ifdef MDU_SPECIAL_CASE_EN
  localparam logic [PAR-1:0] MIN_VAL = {1'b1, {(PAR-1){1'b0}}};
  localparam int             FIFO_W  = $bits(cond_entry_t);

  logic              spc_d;
  logic [PAR-1:0]    spc_res_d;
  cond_entry_t       wr_entry, rd_entry;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

  always_comb begin
    spc_d     = 1'b0;
    spc_res_d = '0;
    if (is_div) begin
      if (rs2_zero) begin
        spc_d     = 1'b1;
        spc_res_d = opc[1] ? rs1 : '1;
      end else if (div_signed && (rs1 == MIN_VAL) && (rs2 == '1)) begin
        spc_d     = 1'b1;
        spc_res_d = (opc == OP_REM) ? '0 : MIN_VAL;
      end
    end
  end

  assign wr_entry          = '{core: core_d, special: spc_d, special_result: spc_res_d};
  assign fifo_wdata        = wr_entry;
  assign rd_entry          = cond_entry_t'(fifo_rdata);
  assign core_q            = rd_entry.core;
  assign io.special        = rd_entry.special;
  assign io.special_result = rd_entry.special_result;
`else
  localparam int FIFO_W = $bits(cond_core_t);

  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

  assign fifo_wdata        = core_d;
  assign core_q            = cond_core_t'(fifo_rdata);
  assign io.special        = 1'b0;
  assign io.special_result = '0;
`endif

  // ---- stage boundary: conditioned entry registered in the FIFO ----
  mdu_cond_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .wr_valid_i (io.in_valid),
    .wr_ready_o (io.in_ready),
    .wdata_i    (fifo_wdata),
    .rd_valid_o (io.out_valid),
    .rd_ready_i (io.out_ready),
    .rdata_o    (fifo_rdata)
  );

  assign io.op0        = core_q.op0;
  assign io.op1        = core_q.op1;
  assign io.opCode_out = core_q.opCode;
  assign io.neg_q      = core_q.neg_q;
  assign io.neg_r      = core_q.neg_r;

endmodule
